// File: rtl/biriscv_mem_pkg.sv
// Shared types and constants for the data-memory initiator and its wait timer.
package biriscv_mem_pkg;

    localparam int unsigned SIZE_OF_THE_BUS = 32;
    localparam int unsigned BE_WIDTH        = 4;
    localparam int unsigned CNT_WIDTH       = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } dmem_state_e;

    // Completion counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/biriscv_req_timer.sv
// Read-wait timer: cleared before WAIT, counts each enabled cycle, flags the last
// allowed cycle.
module biriscv_req_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LastCount = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 8'd0;
        end else if (en && !expired) begin
            count_d = count_q + 8'd1;
        end
    end

    always_comb begin
        expired = (count_q == LastCount);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/biriscv_dmem_initiator.sv
// Single-outstanding data-memory initiator with read timeout and completion counters.
// Optional BIRISCV_DMEM_ALIGN_CHECK_EN rejects commands with a misaligned address.
module biriscv_dmem_initiator
    import biriscv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_wr,
    input  logic [SIZE_OF_THE_BUS-1:0] cmd_addr,
    input  logic [SIZE_OF_THE_BUS-1:0] cmd_data,
    input  logic [BE_WIDTH-1:0]        cmd_be,
    output logic                       dmem_req_valid,
    output logic [SIZE_OF_THE_BUS-1:0] dmem_req_addr,
    output logic [SIZE_OF_THE_BUS-1:0] dmem_req_data,
    output logic [BE_WIDTH-1:0]        dmem_req_write_en,
    input  logic                       dmem_resp_valid,
    input  logic [SIZE_OF_THE_BUS-1:0] dmem_resp_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [SIZE_OF_THE_BUS-1:0] rsp_data,
    output logic                       rsp_error,
    output logic [CNT_WIDTH-1:0]       rd_count,
    output logic [CNT_WIDTH-1:0]       wr_count
);

    dmem_state_e                state_q, state_d;
    logic                       wr_q, wr_d;
    logic [SIZE_OF_THE_BUS-1:0] addr_q, addr_d;
    logic [SIZE_OF_THE_BUS-1:0] data_q, data_d;
    logic [BE_WIDTH-1:0]        be_q, be_d;
    logic [SIZE_OF_THE_BUS-1:0] rsp_data_q, rsp_data_d;
    logic                       rsp_error_q, rsp_error_d;
    logic [CNT_WIDTH-1:0]       rd_count_q, rd_count_d;
    logic [CNT_WIDTH-1:0]       wr_count_q, wr_count_d;

    logic cmd_illegal;
    logic timer_clr;
    logic timer_en;
    logic timer_expired;

    // A write with no enables would look like a read on the bus, so it never goes out.
    always_comb begin
        cmd_illegal = cmd_wr && (cmd_be == '0);
`ifdef BIRISCV_DMEM_ALIGN_CHECK_EN
        cmd_illegal = cmd_illegal || (cmd_addr[1:0] != 2'b00);
`endif
    end

    always_comb begin
        timer_clr = (state_q == ST_REQ);
        timer_en  = (state_q == ST_WAIT);
    end

    biriscv_req_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_req_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (timer_clr),
        .en     (timer_en),
        .expired(timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        data_d      = data_q;
        be_d        = be_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    wr_d        = cmd_wr;
                    addr_d      = cmd_addr;
                    data_d      = cmd_data;
                    be_d        = cmd_be;
                    rsp_data_d  = '0;
                    rsp_error_d = cmd_illegal;
                    state_d     = cmd_illegal ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = wr_q ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                // A response in the expiry cycle still counts as a good read.
                if (dmem_resp_valid) begin
                    rsp_data_d = dmem_resp_data;
                    state_d    = ST_DONE;
                end else if (timer_expired) begin
                    rsp_error_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    if (!rsp_error_q) begin
                        if (wr_q) begin
                            wr_count_d = sat_inc(wr_count_q);
                        end else begin
                            rd_count_d = sat_inc(rd_count_q);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready         = (state_q == ST_IDLE);
        dmem_req_valid    = (state_q == ST_REQ);
        dmem_req_addr     = dmem_req_valid ? addr_q : '0;
        dmem_req_data     = dmem_req_valid ? data_q : '0;
        dmem_req_write_en = (dmem_req_valid && wr_q) ? be_q : '0;
        rsp_valid         = (state_q == ST_DONE);
        rsp_data          = rsp_valid ? rsp_data_q : '0;
        rsp_error         = rsp_valid && rsp_error_q;
        rd_count          = rd_count_q;
        wr_count          = wr_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            be_q        <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            be_q        <= be_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
        end
    end

endmodule

// File: tb/tb_biriscv_dmem_initiator.sv
// Directed bench for biriscv_dmem_initiator: stimulus pushes expected completions,
// a negedge monitor pops and compares them on every response handshake.
module tb_biriscv_dmem_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic [3:0]  cmd_be;
    logic        dmem_req_valid;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_data;
    logic [3:0]  dmem_req_write_en;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    always #5 clk = ~clk;

    biriscv_dmem_initiator #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_wr           (cmd_wr),
        .cmd_addr         (cmd_addr),
        .cmd_data         (cmd_data),
        .cmd_be           (cmd_be),
        .dmem_req_valid   (dmem_req_valid),
        .dmem_req_addr    (dmem_req_addr),
        .dmem_req_data    (dmem_req_data),
        .dmem_req_write_en(dmem_req_write_en),
        .dmem_resp_valid  (dmem_resp_valid),
        .dmem_resp_data   (dmem_resp_data),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .rsp_error        (rsp_error),
        .rd_count         (rd_count),
        .wr_count         (wr_count)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    int          checks  = 0;
    int          errors  = 0;
    int          hs_cnt  = 0;
    int          req_cnt = 0;
    logic [31:0] last_req_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: counts request strobes and scores every completion handshake.
    always @(negedge clk) begin
        rsp_t e;
        if (dmem_req_valid) begin
            req_cnt++;
            last_req_addr = dmem_req_addr;
        end
        if (rst_n && rsp_valid && rsp_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_error", 32'(rsp_error), 32'(e.err));
            end
        end
    end

    task automatic push_exp(input logic [31:0] d, input logic err);
        rsp_t e;
        e.data = d;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    // Returns 1 ns after the accepting edge.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        int n = 0;
        while (!cmd_ready && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_be    = be;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Returns 1 ns after the edge that completes handshake number 'target'.
    task automatic wait_hs(input int target, input int bound);
        int n = 0;
        while (hs_cnt < target && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (hs_cnt < target) check("handshake_timeout", 32'(hs_cnt), 32'(target));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base_req;
        int base_hs;
        int n;
        int guard;

        rst_n           = 1'b1;
        cmd_valid       = 1'b0;
        cmd_wr          = 1'b0;
        cmd_addr        = '0;
        cmd_data        = '0;
        cmd_be          = '0;
        dmem_resp_valid = 1'b0;
        dmem_resp_data  = '0;
        rsp_ready       = 1'b1;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_req_valid", 32'(dmem_req_valid), 32'd0);
        check("rst_req_addr", dmem_req_addr, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_counts", {rd_count, wr_count}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full write
        base_req = req_cnt;
        push_exp(32'd0, 1'b0);
        issue(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
        check("wr_req_valid", 32'(dmem_req_valid), 32'd1);
        check("wr_req_addr", dmem_req_addr, 32'h0000_0100);
        check("wr_req_data", dmem_req_data, 32'hDEAD_BEEF);
        check("wr_req_we", 32'(dmem_req_write_en), 32'hF);
        @(posedge clk);
        #1;
        check("wr_strobe_one_cycle", 32'(dmem_req_valid), 32'd0);
        check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        wait_hs(1, 64);
        check("wr_count_1", 32'(wr_count), 32'd1);
        check("wr_req_pulses", 32'(req_cnt - base_req), 32'd1);

        // Read with a responder holding valid high; completion held off by rsp_ready
        rsp_ready       = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_data  = 32'hDEAD_BEEF;
        push_exp(32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 32'h0000_0100, 32'h0, 4'h0);
        check("rd_req_valid", 32'(dmem_req_valid), 32'd1);
        check("rd_req_we", 32'(dmem_req_write_en), 32'h0);
        check("rd_req_data", dmem_req_data, 32'h0);
        @(posedge clk);
        #1;
        check("rd_lat_2", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        check("rd_lat_3", 32'(rsp_valid), 32'd1);
        check("rd_data_early", rsp_data, 32'hDEAD_BEEF);
        dmem_resp_data = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        check("rd_hold_valid", 32'(rsp_valid), 32'd1);
        check("rd_hold_data", rsp_data, 32'hDEAD_BEEF);
        rsp_ready = 1'b1;
        wait_hs(2, 64);
        check("rd_count_1", 32'(rd_count), 32'd1);

        // Read timeout: 16 WAIT cycles then error
        dmem_resp_valid = 1'b0;
        push_exp(32'd0, 1'b1);
        issue(1'b0, 32'h0000_0200, 32'h0, 4'h0);
        repeat (16) @(posedge clk);
        #1;
        check("to_not_yet", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        check("to_rsp_valid", 32'(rsp_valid), 32'd1);
        wait_hs(3, 64);
        check("to_rd_count", 32'(rd_count), 32'd1);

        // Response in the expiry cycle wins
        dmem_resp_data = 32'hCAFE_F00D;
        push_exp(32'hCAFE_F00D, 1'b0);
        issue(1'b0, 32'h0000_0300, 32'h0, 4'h0);
        repeat (16) @(posedge clk);
        #1;
        check("race_not_yet", 32'(rsp_valid), 32'd0);
        dmem_resp_valid = 1'b1;
        @(posedge clk);
        #1;
        dmem_resp_valid = 1'b0;
        check("race_rsp_valid", 32'(rsp_valid), 32'd1);
        wait_hs(4, 64);
        check("race_rd_count", 32'(rd_count), 32'd2);

        // Write with no byte enables
        base_req = req_cnt;
        push_exp(32'd0, 1'b1);
        issue(1'b1, 32'h0000_0100, 32'h5555_AAAA, 4'h0);
        check("be0_no_req", 32'(dmem_req_valid), 32'd0);
        check("be0_rsp_valid", 32'(rsp_valid), 32'd1);
        wait_hs(5, 64);
        check("be0_req_pulses", 32'(req_cnt - base_req), 32'd0);
        check("be0_wr_count", 32'(wr_count), 32'd1);

        // Misaligned read
        base_req        = req_cnt;
        dmem_resp_valid = 1'b1;
        dmem_resp_data  = 32'h0BAD_F00D;
`ifdef BIRISCV_DMEM_ALIGN_CHECK_EN
        push_exp(32'd0, 1'b1);
        issue(1'b0, 32'h0000_0102, 32'h0, 4'h0);
        wait_hs(6, 64);
        check("mis_req_pulses", 32'(req_cnt - base_req), 32'd0);
        check("mis_rd_count", 32'(rd_count), 32'd2);
`else
        push_exp(32'h0BAD_F00D, 1'b0);
        issue(1'b0, 32'h0000_0102, 32'h0, 4'h0);
        check("mis_req_addr", dmem_req_addr, 32'h0000_0102);
        wait_hs(6, 64);
        check("mis_req_pulses", 32'(req_cnt - base_req), 32'd1);
        check("mis_last_addr", last_req_addr, 32'h0000_0102);
        check("mis_rd_count", 32'(rd_count), 32'd3);
`endif
        dmem_resp_valid = 1'b0;

        // Reset during WAIT abandons the read
        base_hs = hs_cnt;
        issue(1'b0, 32'h0000_0400, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_req_valid", 32'(dmem_req_valid), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_counts", {rd_count, wr_count}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        check("post_rst_no_rsp", 32'(hs_cnt - base_hs), 32'd0);
        check("post_rst_idle", 32'(cmd_ready), 32'd1);

        // Back-to-back writes past the counter limit
        base_hs   = hs_cnt;
        cmd_wr    = 1'b1;
        cmd_addr  = 32'h0000_0800;
        cmd_be    = 4'hF;
        cmd_valid = 1'b1;
        n         = 0;
        guard     = 0;
        while (n < 70000 && guard < 300000) begin
            if (cmd_ready) begin
                push_exp(32'd0, 1'b0);
                cmd_data = 32'(n);
                n++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        cmd_valid = 1'b0;
        check("sat_issued", 32'(n), 32'd70000);
        wait_hs(base_hs + 70000, 300000);
        check("sat_wr_count", 32'(wr_count), 32'h0000_FFFF);
        check("sat_rd_count", 32'(rd_count), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
